stream_checker: RTL and testbench
=================================

# stream_checker

Synthesizable self-checking response checker paired with the team's testbench stimulus flow. Expected values enter a small FIFO through a valid/ready port; each DUT output beat (`act_valid`) pops one expected value and is compared in-order. The block counts matches and mismatches, detects underflow and timeout, and ends with a single pass/fail verdict that benches and FPGA smoke tests both sample.

## Interface
- `DATA_W`, 8: width of expected and actual data.
- `DEPTH`, 16: expected-value FIFO entries; power of two, ≥2.
- `TIMEOUT`, 1024: idle cycles allowed in RUN while expected data is pending; ≥1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear; returns to the reset state.
- `start` in 1: IDLE→RUN pulse.
- `eot` in 1: end-of-test pulse, RUN→DONE.
- `exp_valid` in 1, `exp_ready` out 1, `exp_data` in DATA_W: expected-value push handshake.
- `act_valid` in 1, `act_data` in DATA_W: DUT output beat; no backpressure.
- `done` out 1: in DONE state.
- `pass` out 1: verdict; meaningful only when `done`=1.
- `match_count` out 16, `err_count` out 16: saturating counters.
- `underflow` out 1, `timeout` out 1: sticky flags.
- `first_exp` out DATA_W, `first_act` out DATA_W: first mismatching pair.

## Operation
- States: IDLE, RUN, DONE. IDLE→RUN on `start`. RUN→DONE on `eot` or timeout. DONE holds until `clear`. `start` is ignored outside IDLE; `eot` is ignored outside RUN.
- Push accepted when `exp_valid && exp_ready`. `exp_ready = !full && state!=DONE`. Pushes are legal in IDLE (preload) and RUN.
- Pop/compare only in RUN on `act_valid`:
  - FIFO non-empty: pop head. Equal → `match_count`++; unequal → `err_count`++.
  - FIFO empty: `err_count`++ and set `underflow`.
  - `act_valid` in IDLE/DONE is ignored.
- Push and pop in the same cycle when full: pop occurs, and the push is refused because `exp_ready` is based on the start-of-cycle `full`. Push and pop when empty: the `act_valid` is an underflow, and the pushed value is stored.
- Timeout counter: resets on every `act_valid` and whenever the FIFO is empty. It increments in RUN while the FIFO is non-empty. Reaching TIMEOUT sets `timeout` and moves to DONE.
- Entering DONE: each remaining FIFO entry adds one to `err_count` (missing beats), counted as a bulk add of occupancy, saturating. The FIFO is then flushed.
- `pass = done && err_count==0 && !underflow && !timeout`.
- Counters saturate at 16'hFFFF.
- `clear` and `rst_n` both give: state IDLE; FIFO empty; all counters and flags 0; `exp_ready`=1; `done`/`pass`=0; `first_exp`/`first_act`=0.

## Timing
- `exp_ready` is combinational from the registered occupancy and state.
- Counters and flags update on the edge that samples `act_valid`, so they are visible the next cycle.
- `done` asserts 1 cycle after the `eot` sample, or 1 cycle after the counter reaches TIMEOUT. `pass` is valid in that same cycle.
- Reset mid-RUN discards all state immediately (asynchronous). Deassertion takes effect on the next `clk` edge.

## Configuration
- `STREAM_CHECKER_FIRST_ERR_EN` defined: `first_exp`/`first_act` capture the first mismatching pair (underflow excluded) and hold it until `clear`/reset.
- Macro undefined: both outputs are tied to 0 and no capture registers are built.

## Structure
- Shared include `stream_checker_defs.vh` holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter width constant (16).
- One sub-module, `chk_fifo`: synchronous FIFO, DEPTH entries. Provides `full`, `empty`, `count`, and a flush input.

## Test plan
- All-match: preload 4 values 0x11,0x22,0x33,0x44, `start`, 4 matching `act_valid` beats, `eot` → `match_count`=4, `err_count`=0, `pass`=1 one cycle after `eot`.
- Mismatch: expect 0xA5, drive act 0x5A → `err_count`=1, `pass`=0, `first_exp`=0xA5 and `first_act`=0x5A with FIRST_ERR_EN (0/0 without).
- Underflow/missing: RUN with empty FIFO, one `act_valid` → `underflow`=1, `err_count`=1. Separately, push 3 values and `eot` with no beats → `err_count`=3, FIFO empty.
- Full boundary: push 16 values → `exp_ready`=0. Next cycle pop plus `exp_valid` → push refused, occupancy 15, then `exp_ready`=1.
- Timeout: TIMEOUT=8, 1 value pending, no `act_valid` → `timeout`=1 and `done`=1 after 8 RUN cycles, `pass`=0, `err_count`=1.
- Reset/clear: assert `rst_n`=0 mid-RUN with `err_count`=2 → all outputs 0, `exp_ready`=1, and `start` works again. `clear` in DONE gives the same result.

Source files
------------

// File: rtl/stream_checker_pkg.sv
// Shared types for the stream checker: FSM state encodings, counter width, saturating add.
package stream_checker_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// Synchronous expected-value FIFO with occupancy count and single-cycle flush.
module chk_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_flush,
    input  logic                      i_push,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic                      i_pop,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/stream_checker.sv
// In-order response checker with match/error counters and a pass verdict.
// Define STREAM_CHECKER_FIRST_ERR_EN to capture the first mismatching pair.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_start,
    input  logic              i_eot,
    input  logic              i_exp_valid,
    output logic              o_exp_ready,
    input  logic [DATA_W-1:0] i_exp_data,
    input  logic              i_act_valid,
    input  logic [DATA_W-1:0] i_act_data,
    output logic              o_done,
    output logic              o_pass,
    output logic [CNT_W-1:0]  o_match_count,
    output logic [CNT_W-1:0]  o_err_count,
    output logic              o_underflow,
    output logic              o_timeout,
    output logic [DATA_W-1:0] o_first_exp,
    output logic [DATA_W-1:0] o_first_act
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e            r_state, w_state_next;
    logic [CNT_W-1:0]  r_match, w_match_next;
    logic [CNT_W-1:0]  r_err, w_err_next;
    logic [CNT_W-1:0]  w_err_add;
    logic              r_underflow, r_timeout;
    logic [TW-1:0]     r_to_cnt, w_to_next;
    logic              w_to_hit;
    logic              w_full, w_empty;
    logic [CW-1:0]     w_count, w_remaining;
    logic [DATA_W-1:0] w_head;
    logic              w_push, w_beat, w_pop, w_mismatch, w_uflow_beat;
    logic              w_enter_done, w_flush;

    assign o_exp_ready  = !w_full && (r_state != StDone);
    assign w_push       = i_exp_valid && o_exp_ready;
    assign w_beat       = (r_state == StRun) && i_act_valid;
    assign w_pop        = w_beat && !w_empty;
    assign w_mismatch   = w_pop && (w_head != i_act_data);
    assign w_uflow_beat = w_beat && w_empty;
    assign w_enter_done = (r_state == StRun) && (i_eot || w_to_hit);
    assign w_flush      = i_clear || w_enter_done;
    // Entries left once this cycle's push/pop land are the missing beats.
    assign w_remaining  = w_count + CW'(w_push) - CW'(w_pop);

    chk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (i_exp_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StRun;
            StRun:   if (i_eot || w_to_hit) w_state_next = StDone;
            StDone:  w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_to_next = '0;
        w_to_hit  = 1'b0;
        if ((r_state == StRun) && !i_act_valid && !w_empty) begin
            w_to_next = r_to_cnt + TW'(1);
            w_to_hit  = (w_to_next >= TW'(TIMEOUT));
        end
    end

    always_comb begin
        w_match_next = r_match;
        if (w_pop && !w_mismatch) w_match_next = sat_add(r_match, CNT_W'(1));
        w_err_add  = CNT_W'(w_mismatch || w_uflow_beat) +
                     (w_enter_done ? CNT_W'(w_remaining) : '0);
        w_err_next = sat_add(r_err, w_err_add);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_match     <= '0;
            r_err       <= '0;
            r_underflow <= 1'b0;
            r_timeout   <= 1'b0;
            r_to_cnt    <= '0;
        end else if (i_clear) begin
            r_state     <= StIdle;
            r_match     <= '0;
            r_err       <= '0;
            r_underflow <= 1'b0;
            r_timeout   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_match     <= w_match_next;
            r_err       <= w_err_next;
            r_underflow <= r_underflow | w_uflow_beat;
            r_timeout   <= r_timeout | w_to_hit;
            r_to_cnt    <= w_to_next;
        end
    end

    assign o_done        = (r_state == StDone);
    assign o_pass        = o_done && (r_err == '0) && !r_underflow && !r_timeout;
    assign o_match_count = r_match;
    assign o_err_count   = r_err;
    assign o_underflow   = r_underflow;
    assign o_timeout     = r_timeout;

`ifdef STREAM_CHECKER_FIRST_ERR_EN
    logic              r_first_vld;
    logic [DATA_W-1:0] r_first_exp, r_first_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_vld <= 1'b0;
            r_first_exp <= '0;
            r_first_act <= '0;
        end else if (i_clear) begin
            r_first_vld <= 1'b0;
            r_first_exp <= '0;
            r_first_act <= '0;
        end else if (w_mismatch && !r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_exp <= w_head;
            r_first_act <= i_act_data;
        end
    end

    assign o_first_exp = r_first_exp;
    assign o_first_act = r_first_act;
`else
    assign o_first_exp = '0;
    assign o_first_act = '0;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker (TIMEOUT shortened to 8).
module tb_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_clear = 1'b0, i_start = 1'b0, i_eot = 1'b0;
    logic        i_exp_valid = 1'b0, i_act_valid = 1'b0;
    logic [7:0]  i_exp_data = '0, i_act_data = '0;
    logic        o_exp_ready, o_done, o_pass, o_underflow, o_timeout;
    logic [15:0] o_match_count, o_err_count;
    logic [7:0]  o_first_exp, o_first_act;

    int n_checks = 0;
    int n_errors = 0;

`ifdef STREAM_CHECKER_FIRST_ERR_EN
    localparam logic [7:0] FirstExp = 8'hA5;
    localparam logic [7:0] FirstAct = 8'h5A;
`else
    localparam logic [7:0] FirstExp = 8'h00;
    localparam logic [7:0] FirstAct = 8'h00;
`endif

    always #5 clk = ~clk;

    stream_checker #(
        .DATA_W  (8),
        .DEPTH   (16),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (i_clear),
        .i_start       (i_start),
        .i_eot         (i_eot),
        .i_exp_valid   (i_exp_valid),
        .o_exp_ready   (o_exp_ready),
        .i_exp_data    (i_exp_data),
        .i_act_valid   (i_act_valid),
        .i_act_data    (i_act_data),
        .o_done        (o_done),
        .o_pass        (o_pass),
        .o_match_count (o_match_count),
        .o_err_count   (o_err_count),
        .o_underflow   (o_underflow),
        .o_timeout     (o_timeout),
        .o_first_exp   (o_first_exp),
        .o_first_act   (o_first_act)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        i_exp_valid = 1'b1;
        i_exp_data  = d;
        tick();
        i_exp_valid = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d);
        i_act_valid = 1'b1;
        i_act_data  = d;
        tick();
        i_act_valid = 1'b0;
    endtask

    task automatic do_start();
        i_start = 1'b1; tick(); i_start = 1'b0;
    endtask

    task automatic do_eot();
        i_eot = 1'b1; tick(); i_eot = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1; tick(); i_clear = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"},  {31'd0, o_done}, 32'd0);
        check({tag, "_pass"},  {31'd0, o_pass}, 32'd0);
        check({tag, "_ready"}, {31'd0, o_exp_ready}, 32'd1);
        check({tag, "_match"}, {16'd0, o_match_count}, 32'd0);
        check({tag, "_err"},   {16'd0, o_err_count}, 32'd0);
        check({tag, "_flags"}, {30'd0, o_underflow, o_timeout}, 32'd0);
        check({tag, "_first"}, {16'd0, o_first_exp, o_first_act}, 32'd0);
    endtask

    initial begin
        #12;
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // All-match
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        do_start();
        beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
        do_eot();
        check("allm_done",  {31'd0, o_done}, 32'd1);
        check("allm_pass",  {31'd0, o_pass}, 32'd1);
        check("allm_match", {16'd0, o_match_count}, 32'd4);
        check("allm_err",   {16'd0, o_err_count}, 32'd0);
        check("allm_ready", {31'd0, o_exp_ready}, 32'd0);
        do_clear();
        check_idle("clr1");

        // Mismatch
        push(8'hA5);
        do_start();
        beat(8'h5A);
        do_eot();
        check("mm_err",   {16'd0, o_err_count}, 32'd1);
        check("mm_match", {16'd0, o_match_count}, 32'd0);
        check("mm_pass",  {31'd0, o_pass}, 32'd0);
        check("mm_fexp",  {24'd0, o_first_exp}, {24'd0, FirstExp});
        check("mm_fact",  {24'd0, o_first_act}, {24'd0, FirstAct});
        do_clear();

        // Underflow
        do_start();
        beat(8'h00);
        check("uf_flag", {31'd0, o_underflow}, 32'd1);
        check("uf_err",  {16'd0, o_err_count}, 32'd1);
        check("uf_done", {31'd0, o_done}, 32'd0);
        do_eot();
        check("uf_pass", {31'd0, o_pass}, 32'd0);
        do_clear();

        // Missing beats counted at eot
        push(8'h01); push(8'h02); push(8'h03);
        do_start();
        do_eot();
        check("miss_err",  {16'd0, o_err_count}, 32'd3);
        check("miss_uf",   {31'd0, o_underflow}, 32'd0);
        check("miss_pass", {31'd0, o_pass}, 32'd0);
        do_clear();

        // Full boundary: pop + push while full refuses the push
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_ready", {31'd0, o_exp_ready}, 32'd0);
        do_start();
        i_act_valid = 1'b1; i_act_data = 8'h00;
        i_exp_valid = 1'b1; i_exp_data = 8'hEE;
        tick();
        i_act_valid = 1'b0; i_exp_valid = 1'b0;
        check("full_ready_after", {31'd0, o_exp_ready}, 32'd1);
        check("full_match", {16'd0, o_match_count}, 32'd1);
        do_eot();
        check("full_missing", {16'd0, o_err_count}, 32'd15);
        do_clear();

        // Timeout after 8 idle RUN cycles with one pending value
        push(8'h77);
        do_start();
        for (int i = 0; i < 7; i++) tick();
        check("to_early_done", {31'd0, o_done}, 32'd0);
        tick();
        check("to_done", {31'd0, o_done}, 32'd1);
        check("to_flag", {31'd0, o_timeout}, 32'd1);
        check("to_pass", {31'd0, o_pass}, 32'd0);
        check("to_err",  {16'd0, o_err_count}, 32'd1);
        do_clear();

        // Asynchronous reset mid-RUN
        do_start();
        beat(8'h00); beat(8'h00);
        check("rst_pre_err", {16'd0, o_err_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        #1;
        rst_n = 1'b1;
        tick();
        do_start();
        do_eot();
        check("rst_restart_done", {31'd0, o_done}, 32'd1);
        check("rst_restart_pass", {31'd0, o_pass}, 32'd1);
        do_clear();
        check_idle("clr_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
